// File: rtl/z80_trace_pkg.sv
// Shared types and bus-decode helpers for the Z80 bus tracer.
package z80_trace_pkg;

   // Bus cycle class recorded in the top three bits of every trace record.
   typedef enum logic [2:0] {
      M1   = 3'd0,
      MR   = 3'd1,
      MW   = 3'd2,
      IR   = 3'd3,
      IW   = 3'd4,
      INTA = 3'd5
   } trc_type_e;

   // Wait-injection FSM states.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACTIVE,
      ST_COMMIT
   } trc_state_e;

   localparam int TRC_TS_W = 16;

   // Record fields that do not depend on the timestamp width.
   typedef struct packed {
      trc_type_e   typ;
      logic [15:0] addr;
      logic [7:0]  data;
   } trc_hdr_t;

   // Full record layout at the default timestamp width.
   typedef struct packed {
      trc_type_e             typ;
      logic [15:0]           addr;
      logic [7:0]            data;
      logic [TRC_TS_W-1:0]   ts;
   } trc_rec_t;

   // True when the strobe combination forms any recognised bus cycle.
   function automatic logic bus_hit(input logic n_mreq, input logic n_iorq,
                                    input logic n_rd, input logic n_wr,
                                    input logic n_m1);
      return (!n_mreq && (!n_rd || !n_wr)) ||
             (!n_iorq && (!n_m1 || !n_rd || !n_wr));
   endfunction

   // Priority decode of the cycle class; only meaningful when bus_hit is true.
   function automatic trc_type_e bus_decode(input logic n_mreq, input logic n_iorq,
                                            input logic n_rd, input logic n_wr,
                                            input logic n_m1);
      if (!n_m1 && !n_mreq && !n_rd) return M1;
      if (!n_m1 && !n_iorq)          return INTA;
      if (!n_mreq && !n_rd)          return MR;
      if (!n_mreq && !n_wr)          return MW;
      if (!n_iorq && !n_rd)          return IR;
      return IW;
   endfunction

   // The strobe whose release ends a cycle of the given class is still low.
   function automatic logic qual_low(input trc_type_e t, input logic n_iorq,
                                     input logic n_rd, input logic n_wr);
      case (t)
         INTA:    return !n_iorq;
         MW, IW:  return !n_wr;
         default: return !n_rd;
      endcase
   endfunction

endpackage

// File: rtl/z80_trace_fifo.sv
// Synchronous trace FIFO; pointers carry an extra wrap bit for full/empty.
module z80_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             rd_ok;
   logic             wr_ok;

   // A pop frees the slot first, so a push into a full FIFO with a pop succeeds.
   assign rd_ok = pop && !empty;
   assign wr_ok = push && (!full || rd_ok);

   assign level = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (level == (AW+1)'(DEPTH));
   assign rdata = mem[rd_ptr[AW-1:0]];

   // Pointer update for accepted pushes and pops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Record storage; contents need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus monitor: logs each bus cycle into a trace FIFO and
// stretches cycles with programmable wait states via nWAIT.
module z80_bus_tracer
   import z80_trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   parameter int WAIT_W = 4,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [WAIT_W-1:0]        wait_mem,
   input  logic [WAIT_W-1:0]        wait_io,
   input  logic [WAIT_W-1:0]        wait_m1,
   input  logic                     nMREQ,
   input  logic                     nIORQ,
   input  logic                     nRD,
   input  logic                     nWR,
   input  logic                     nM1,
   input  logic [15:0]              A,
   input  logic [7:0]               D,
   output logic                     nWAIT,
   output logic                     trc_valid,
   input  logic                     trc_ready,
   output logic [3+16+8+TS_W-1:0]   trc_data,
   output logic [$clog2(DEPTH):0]   trc_level,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt
);
   localparam int REC_W = 3 + 16 + 8 + TS_W;

   trc_state_e        state;
   trc_type_e         cyc_type;
   trc_type_e         dec_type;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] start_wait;
   logic [TS_W-1:0]   ts;
   logic [TS_W-1:0]   ts_start;
   logic [15:0]       addr_cap;
   logic [7:0]        data_cap;
   logic              prev_mreq, prev_iorq, prev_rd, prev_wr, prev_m1;
   logic              start;
   logic              cur_low;
   logic              push;
   logic              pop_fire;
   logic              fifo_full;
   logic              fifo_empty;
   trc_hdr_t          hdr;
   logic [REC_W-1:0]  rec;

   function automatic logic [WAIT_W-1:0] wait_sel(input trc_type_e t);
      case (t)
         M1:      return wait_m1;
         MR, MW:  return wait_mem;
         default: return wait_io;
      endcase
   endfunction

   // A cycle starts when a valid strobe combination appears that was absent last clk.
   assign dec_type   = bus_decode(nMREQ, nIORQ, nRD, nWR, nM1);
   assign start_wait = wait_sel(dec_type);
   assign start      = enable && (state == ST_IDLE) &&
                       bus_hit(nMREQ, nIORQ, nRD, nWR, nM1) &&
                       !bus_hit(prev_mreq, prev_iorq, prev_rd, prev_wr, prev_m1);
   assign cur_low    = qual_low(cyc_type, nIORQ, nRD, nWR);

   assign push      = (state == ST_COMMIT);
   assign pop_fire  = trc_valid && trc_ready;
   assign trc_valid = !fifo_empty;
   assign hdr       = '{typ: cyc_type, addr: addr_cap, data: data_cap};
   assign rec       = {hdr, ts_start};

   // Strobe history for start detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_mreq <= 1'b1;
         prev_iorq <= 1'b1;
         prev_rd   <= 1'b1;
         prev_wr   <= 1'b1;
         prev_m1   <= 1'b1;
      end else begin
         prev_mreq <= nMREQ;
         prev_iorq <= nIORQ;
         prev_rd   <= nRD;
         prev_wr   <= nWR;
         prev_m1   <= nM1;
      end
   end

   // Timestamp and wait-injection FSM; nWAIT is a registered output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts       <= '0;
         ts_start <= '0;
         state    <= ST_IDLE;
         cyc_type <= M1;
         wait_cnt <= '0;
         nWAIT    <= 1'b1;
      end else begin
         if (enable) ts <= ts + 1'b1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cyc_type <= dec_type;
                  ts_start <= ts;
                  if (start_wait != '0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= start_wait;
                     nWAIT    <= 1'b0;
                  end else begin
                     state <= ST_ACTIVE;
                  end
               end
            end
            ST_WAIT: begin
               if (!cur_low) begin
                  // Strobe released during the wait: glitch, drop the cycle.
                  state <= ST_IDLE;
                  nWAIT <= 1'b1;
               end else if (wait_cnt == WAIT_W'(1)) begin
                  state <= ST_ACTIVE;
                  nWAIT <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (!cur_low) state <= ST_COMMIT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Address/data capture while the qualifying strobe is low.
   always_ff @(posedge clk) begin
      if (start || (((state == ST_WAIT) || (state == ST_ACTIVE)) && cur_low)) begin
         addr_cap <= A;
         data_cap <= D;
      end
   end

   // Dropped-record bookkeeping: sticky overflow and saturating count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (push && fifo_full && !pop_fire) begin
         overflow <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   z80_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (rec),
      .pop   (pop_fire),
      .rdata (trc_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (trc_level)
   );

endmodule
